// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clock-divider / reset-sequencer block.
//   seq_state_e : sequencer states
//   DIV_MIN     : smallest divisor a channel will accept
//   half_div    : length of the high phase for divisor D
package clkgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  localparam int DIV_MIN = 2;

  function automatic logic [31:0] half_div(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clkgen_div_ch.sv
// One divided-clock channel: period counter, active/pending divisor, registered
// clk_out and tick.
//   clk, reset : fabric clock, asynchronous active-high reset
//   act        : channel counts in the coming cycle (sequencer not in WAIT_LOCK)
//   ld_now     : load wdiv into the active divisor immediately
//   ld_pend    : queue wdiv, applied at the next period wrap
//   wdiv       : divisor being written
//   pending    : a queued divisor is waiting for the wrap
//   clk_out    : divided clock, high for the first floor(D/2) counts
//   tick       : high in the cycle the count is 0
module clkgen_div_ch
  import clkgen_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             act,
  input  logic             ld_now,
  input  logic             ld_pend,
  input  logic [DIV_W-1:0] wdiv,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             act_q;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    if (ld_now) div_d = wdiv;
    if (!act) begin
      // lock lost or never gained: counter parked, queued write discarded
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (!act_q) begin
      cnt_d = '0;
    end else if (cnt_q == div_q - DIV_W'(1)) begin
      // wrap: the only point a queued divisor takes effect, so no runt pulse
      cnt_d = '0;
      if (pend_q) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (act && ld_pend) begin
      pend_d = 1'b1;
      pdiv_d = wdiv;
    end
    // outputs registered from the next count so they line up with cnt_q
    clk_d  = act && (cnt_d < DIV_W'(half_div(32'(div_d))));
    tick_d = act && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= DIV_W'(DEFAULT_DIV);
      pend_q <= 1'b0;
      act_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      act_q  <= act;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  // queued divisor value is only meaningful while pend_q is set
  always_ff @(posedge clk) begin
    pdiv_q <= pdiv_d;
  end

  assign pending = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clkgen_rstseq.sv
// Multi-channel clock divider with lock-driven reset sequencer.
//   clk, reset : fabric clock, asynchronous active-high reset
//   locked     : MMCM lock, asynchronous; synchronised here
//   cfg_*      : divisor write port (valid/ready), cfg_err pulses on a rejected write
//   clk_out    : divided clocks        tick    : 1-cycle pulse as clk_out rises
//   rst_out    : per-channel resets    run     : sequencer in RUN
module clkgen_rstseq
  import clkgen_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int DIV_W       = 16,
  parameter  int DEFAULT_DIV = 256,
  parameter  int RST_HOLD    = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] rst_out,
  output logic              run
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  seq_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [NUM_CH-1:0]      rst_q, rst_d;
  logic                   err_q, err_d;
  logic [NUM_CH-1:0]      pend, ld_now, ld_pend;
  logic                   ch_ok, div_ok, acc, act;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      WAIT_LOCK: begin
        hold_d = '0;
        if (lock_s) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s)                               state_d = WAIT_LOCK;
        else if (hold_q == HOLD_W'(RST_HOLD - 1))  state_d = RUN;
        else                                       hold_d  = hold_q + HOLD_W'(1);
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign act = (state_d != WAIT_LOCK);

  always_comb begin
    cfg_ready = 1'b1;
    ch_ok     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ch_ok = 1'b1;
        if (pend[i]) cfg_ready = 1'b0;
      end
    end
  end

  assign acc    = cfg_valid & cfg_ready;
  assign div_ok = (cfg_div >= DIV_W'(DIV_MIN));
  assign err_d  = acc & ~(ch_ok & div_ok);

  always_comb begin
    ld_now  = '0;
    ld_pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc && div_ok && cfg_ch == CH_W'(i)) begin
        if (state_q == WAIT_LOCK) ld_now[i]  = 1'b1;
        else                      ld_pend[i] = 1'b1;
      end
    end
  end

  // a channel leaves reset the cycle after its first tick seen in RUN;
  // heading back to WAIT_LOCK overrides any release
  always_comb begin
    if (state_d == WAIT_LOCK) rst_d = '1;
    else                      rst_d = rst_q & ~(tick & {NUM_CH{state_q == RUN}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
      rst_q   <= '1;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      rst_q   <= rst_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkgen_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .act     (act),
      .ld_now  (ld_now[g]),
      .ld_pend (ld_pend[g]),
      .wdiv    (cfg_div),
      .pending (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

  assign rst_out = rst_q;
  assign cfg_err = err_q;
  assign run     = (state_q == RUN);

endmodule

// File: tb/tb_clkgen_rstseq.sv
module tb_clkgen_rstseq;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 256;
  localparam int RST_HOLD    = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CH_W        = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              locked;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] rst_out;
  logic              run;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clkgen_rstseq #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .RST_HOLD    (RST_HOLD),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .rst_out   (rst_out),
    .run       (run)
  );

  // Reference model: time-based. Each channel remembers the cycle its current
  // period began (m_t0) and that period's length (m_d); outputs follow from the
  // elapsed time. The channels are active whenever the lock sampled
  // SYNC_STAGES edges earlier was high.
  int m_t;
  int m_t0[NUM_CH];
  int m_d[NUM_CH];
  int m_pd[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_rel[NUM_CH];
  bit m_act;
  int m_hs;
  bit m_p1, m_p2;
  bit m_err;

  function automatic void m_reset();
    m_t = 0; m_act = 0; m_hs = 0; m_p1 = 0; m_p2 = 0; m_err = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_t0[c] = 0; m_d[c] = DEFAULT_DIV; m_pd[c] = 0; m_pend[c] = 0; m_rel[c] = 0;
    end
  endfunction

  function automatic logic [NUM_CH-1:0] m_clk();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_act && ((m_t - m_t0[c]) < m_d[c] / 2);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] m_tick();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_act && (m_t == m_t0[c]);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] m_rst();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = !m_rel[c];
    return r;
  endfunction

  function automatic bit m_run();
    return m_act && ((m_t - m_hs) >= RST_HOLD);
  endfunction

  function automatic bit m_ready(input int ch);
    if (ch >= NUM_CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic logic [10:0] m_vec();
    return {m_clk(), m_tick(), m_rst(), m_run(), m_err};
  endfunction

  // advance the model across one rising edge using the inputs now applied
  function automatic void m_edge();
    logic [NUM_CH-1:0] tk_o;
    bit run_o, act_n, acc;
    int ch;
    tk_o  = m_tick();
    run_o = m_run();
    ch    = int'(cfg_ch);
    acc   = cfg_valid && m_ready(ch);
    act_n = m_p2;
    m_p2  = m_p1;
    m_p1  = locked;
    m_t++;
    if (act_n && !m_act) m_hs = m_t;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!act_n) begin
        m_pend[c] = 0;
        m_rel[c]  = 0;
      end else if (!m_act) begin
        m_t0[c] = m_t;
      end else begin
        if (m_t - m_t0[c] == m_d[c]) begin
          m_t0[c] = m_t;
          if (m_pend[c]) begin
            m_d[c]    = m_pd[c];
            m_pend[c] = 0;
          end
        end
        if (run_o && tk_o[c]) m_rel[c] = 1;
      end
    end
    m_err = 0;
    if (acc) begin
      if (ch >= NUM_CH || int'(cfg_div) < 2) m_err = 1;
      else if (!m_act) m_d[ch] = int'(cfg_div);
      else if (act_n) begin
        m_pend[ch] = 1;
        m_pd[ch]   = int'(cfg_div);
      end
    end
    m_act = act_n;
  endfunction

  task automatic cyc();
    m_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({clk_out, tick, rst_out, run, cfg_err, cfg_ready} !== {3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", {clk_out, tick, rst_out, run, cfg_err, cfg_ready},
               {3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1});
    end
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 100; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run} !== {3'b000, 3'b000, 3'b111, 1'b0}) begin
        errors++;
        $display("FAIL wait_lock t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run}, {3'b000, 3'b000, 3'b111, 1'b0});
      end
    end
  endtask

  task automatic test_lock();
    int rise, run_at, rstf_at;
    run_at = -1; rstf_at = -1;
    locked = 1'b1;
    rise = m_t;
    for (int i = 0; i < 300; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL lock_seq t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
      if (run === 1'b1 && run_at < 0) run_at = m_t - rise;
      if (rst_out[0] === 1'b0 && rstf_at < 0) rstf_at = m_t - rise;
    end
    checks++;
    if (run_at !== SYNC_STAGES + 1 + RST_HOLD) begin
      errors++;
      $display("FAIL run_latency got=%0d exp=%0d", run_at, SYNC_STAGES + 1 + RST_HOLD);
    end
    checks++;
    if (rstf_at !== SYNC_STAGES + 1 + DEFAULT_DIV + 1) begin
      errors++;
      $display("FAIL rst_release got=%0d exp=%0d", rstf_at, SYNC_STAGES + 2 + DEFAULT_DIV);
    end
  endtask

  task automatic test_cfg();
    int len, n2;
    bit seen_fall;
    len = 0; n2 = 0; seen_fall = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_first_ready got=%b exp=1", cfg_ready);
    end
    cyc();
    cfg_div = 16'd7;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_stall_ready got=%b exp=0", cfg_ready);
    end
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL cfg_switch t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
      if (clk_out[1] === 1'b1) len++;
      else if (len > 0) begin
        if (seen_fall) begin
          checks++;
          if (len != 128 && len != 2) begin
            errors++;
            $display("FAIL ch1_high_len got=%0d exp=128_or_2", len);
          end
          if (len == 2) n2++;
        end
        seen_fall = 1;
        len = 0;
      end
    end
    checks++;
    if (n2 < 10) begin
      errors++;
      $display("FAIL ch1_new_period got=%0d short_pulses exp=at_least_10", n2);
    end
  endtask

  task automatic test_err();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1;
    #1;
    cyc();
    checks++;
    if (cfg_err !== 1'b1 || cfg_err !== m_err) begin
      errors++;
      $display("FAIL err_small_div got=%b exp=1", cfg_err);
    end
    cfg_ch = 2'd3; cfg_div = 16'd10;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_badch_ready got=%b exp=1", cfg_ready);
    end
    cyc();
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_bad_ch got=%b exp=1", cfg_err);
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL err_after t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
    end
  endtask

  task automatic test_lock_loss();
    int rise, run_at, nt;
    run_at = -1; nt = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd9;
    #1;
    cyc();
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL loss_pending_ready got=%b exp=0", cfg_ready);
    end
    locked = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL loss_seq t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
    end
    checks++;
    if ({rst_out, clk_out, cfg_ready} !== {3'b111, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL loss_cleared got=%b exp=%b", {rst_out, clk_out, cfg_ready}, {3'b111, 3'b000, 1'b1});
    end
    locked = 1'b1;
    rise = m_t;
    for (int i = 0; i < 300; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL relock_seq t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
      if (run === 1'b1 && run_at < 0) run_at = m_t - rise;
      if (tick[1] === 1'b1) nt++;
    end
    checks++;
    if (run_at !== SYNC_STAGES + 1 + RST_HOLD) begin
      errors++;
      $display("FAIL relock_latency got=%0d exp=%0d", run_at, SYNC_STAGES + 1 + RST_HOLD);
    end
    checks++;
    if (nt !== 60) begin
      errors++;
      $display("FAIL relock_ch1_ticks got=%0d exp=60", nt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_div   = DIV_W'($urandom_range(0, 12));
      if ($urandom_range(0, 399) == 0) locked = ~locked;
      #1;
      checks++;
      if (cfg_ready !== m_ready(int'(cfg_ch))) begin
        errors++;
        $display("FAIL rand_ready t=%0d ch=%0d got=%b exp=%b", m_t, cfg_ch, cfg_ready, m_ready(int'(cfg_ch)));
      end
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL rand_seq t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
    end
    cfg_valid = 1'b0;
    locked = 1'b1;
  endtask

  task automatic test_async_reset();
    int nt;
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL pre_reset t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({clk_out, tick, rst_out, run, cfg_err, cfg_ready} !== {3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", {clk_out, tick, rst_out, run, cfg_err, cfg_ready},
               {3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 300; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, rst_out, run, cfg_err} !== m_vec()) begin
        errors++;
        $display("FAIL post_reset t=%0d got=%b exp=%b", m_t, {clk_out, tick, rst_out, run, cfg_err}, m_vec());
      end
      if (tick[1] === 1'b1) nt++;
    end
    checks++;
    if (nt !== 2) begin
      errors++;
      $display("FAIL default_div_ch1_ticks got=%0d exp=2", nt);
    end
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    m_reset();
    test_reset();
    test_lock();
    test_cfg();
    test_err();
    test_lock_loss();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
